ysyx_22050019_stage_buf: RTL and testbench
==========================================

# ysyx_22050019_stage_buf

Parametrised pipeline-stage buffer for the ysyx_22050019 core, the successor to the fixed-field stall-only stage registers. It carries an opaque payload of DATA_W bits plus a commit flag between two stages with a valid/ready handshake, a flush, and an optional two-entry skid so upstream ready is registered. It also produces a registered retire pulse and a retired-instruction counter for difftest and perf.

## Interface
- DATA_W, 169: payload width: pc 64 + inst 32 + we 1 + waddr 5 + wdata 64 + 3 spare bits.
- CNT_W, 64: retire counter width.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  upstream entry valid.
- in_ready_o  out  1  buffer can accept this cycle.
- in_data_i  in  DATA_W  upstream payload.
- in_commit_i  in  1  entry retires an instruction.
- flush_i  in  1  discard all held entries.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream accepts head.
- out_data_o  out  DATA_W  head payload.
- out_commit_o  out  1  head commit flag.
- retire_o  out  1  registered pulse, one committed entry left last cycle.
- retire_cnt_o  out  CNT_W  total committed entries delivered.

## Operation
- Fires: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- Storage: head register (out_*), plus skid register when YSYX_STAGE_SKID_EN is defined.
- States with skid: EMPTY (head invalid), ONE (head valid, skid empty), TWO (both valid).
  - EMPTY: in_fire -> ONE, input loads head.
  - ONE: in_fire & out_fire -> ONE, input loads head; in_fire only -> TWO, input loads skid; out_fire only -> EMPTY.
  - TWO: in_ready_o = 0. out_fire -> ONE, skid moves to head.
  - in_ready_o = (state != TWO), driven from a flop.
- Ordering strictly FIFO. No entry is duplicated or dropped except by flush.
- Flush: next state EMPTY, and in_valid_i is ignored that cycle. Payload registers keep their values; only the valid bits clear.
- Flush with simultaneous out_fire: the head counts as delivered, so the retire pulse and count apply if its commit flag is set.
- Retire: at each edge with out_fire & out_commit_o, retire_o <= 1 and retire_cnt_o increments by 1. Otherwise retire_o <= 0.
- Counter wraps modulo 2^CNT_W, from all-ones to 0, with no saturation.
- Commit flag is stored alongside the payload and moves with it through skid to head.

## Timing
- Reset: out_valid_o = 0, out_commit_o = 0, out_data_o = 0, retire_o = 0, retire_cnt_o = 0, skid cleared. in_ready_o = 1 during and after reset.
- Latency: an entry accepted at edge N is visible on out_* after edge N, so out_valid_o is high in cycle N+1.
- Throughput: one entry per cycle sustained when out_ready_i = 1.
- out_data_o and out_valid_o are stable while out_valid_o = 1 and out_ready_i = 0.
- retire_o and retire_cnt_o update one edge after the out_fire that caused them.
- Reset asserted mid-operation: all state returns to reset values immediately. Held entries are lost; no retire pulse is produced.

## Configuration
- YSYX_STAGE_SKID_EN defined: two-entry skid as above. in_ready_o is a pure register output with no combinational path from out_ready_i.
- Not defined: head register only, with states EMPTY/FULL.
  - in_ready_o = ~out_valid_o | out_ready_i, combinational.
  - Same fire, flush, retire and reset rules.
  - Throughput is still one entry per cycle.

## Test plan
- Reset then stream of 8 entries, in_valid_i = 1, out_ready_i = 1, data 0x1..0x8, all commit: outputs 0x1..0x8 on consecutive cycles starting 1 cycle after first accept. retire_cnt_o = 8 two cycles after the last in_fire, since the last entry leaves one cycle after acceptance and the count updates one edge later.
- Backpressure (skid on): out_ready_i = 0 with entries 0xA, 0xB, 0xC offered. 0xA and 0xB are accepted; in_ready_o = 0 the cycle after 0xB is accepted; 0xC is held upstream. With out_ready_i = 1 the output order is 0xA, 0xB, 0xC.
- Flush in TWO with out_ready_i = 0: next cycle out_valid_o = 0, in_ready_o = 1, retire_cnt_o unchanged. Repeat with out_ready_i = 1 and head commit = 1: retire_cnt_o increments by 1.
- Mixed commit flags 1, 0, 1, 0: exactly 2 retire_o pulses, each 1 cycle wide; retire_cnt_o = 2.
- CNT_W = 4, 17 committed entries: retire_cnt_o reads 15 after the 15th and 0 after the 16th, then ends at 1.
- rst_n dropped asynchronously while in TWO: all outputs return to reset values before the next clock edge; a stream restarted after release behaves as in scenario 1.

Source files
------------

// File: rtl/ysyx_22050019_stage_buf.sv
// Pipeline-stage buffer: payload + commit flag behind a valid/ready handshake, with flush and retire counter.
// Define YSYX_STAGE_SKID_EN for a two-entry skid with a registered in_ready_o; otherwise a single head register.
module ysyx_22050019_stage_buf #(
  parameter int unsigned DATA_W = 169,
  parameter int unsigned CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_commit_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_commit_o,
  output logic              retire_o,
  output logic [CNT_W-1:0]  retire_cnt_o
);

  logic              in_fire;
  logic              out_fire;
  logic              load_head_in;
  logic [DATA_W-1:0] head_data;
  logic              head_commit;

  assign in_fire      = in_valid_i & in_ready_o;
  assign out_fire     = out_valid_o & out_ready_i;
  assign out_data_o   = head_data;
  assign out_commit_o = head_commit;

`ifdef YSYX_STAGE_SKID_EN
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t            state_q, state_d;
  logic              ready_q;
  logic              load_skid_in;
  logic              move_skid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_commit;

  assign in_ready_o  = ready_q;
  assign out_valid_o = (state_q != S_EMPTY);

  always_comb begin
    state_d      = state_q;
    load_head_in = 1'b0;
    load_skid_in = 1'b0;
    move_skid    = 1'b0;
    unique case (state_q)
      S_EMPTY: if (in_fire) begin
        state_d      = S_ONE;
        load_head_in = 1'b1;
      end
      S_ONE: begin
        if (in_fire && out_fire) begin
          load_head_in = 1'b1;
        end else if (in_fire) begin
          state_d      = S_TWO;
          load_skid_in = 1'b1;
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: if (out_fire) begin
        state_d   = S_ONE;
        move_skid = 1'b1;
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush drops the incoming entry and clears validity; payload registers hold.
    if (flush_i) begin
      state_d      = S_EMPTY;
      load_head_in = 1'b0;
      load_skid_in = 1'b0;
      move_skid    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      ready_q     <= 1'b1;
      head_data   <= '0;
      head_commit <= 1'b0;
      skid_data   <= '0;
      skid_commit <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != S_TWO);
      if (load_head_in) begin
        head_data   <= in_data_i;
        head_commit <= in_commit_i;
      end else if (move_skid) begin
        head_data   <= skid_data;
        head_commit <= skid_commit;
      end
      if (load_skid_in) begin
        skid_data   <= in_data_i;
        skid_commit <= in_commit_i;
      end
    end
  end
`else
  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t state_q, state_d;

  assign out_valid_o = (state_q == S_FULL);
  assign in_ready_o  = ~out_valid_o | out_ready_i;

  always_comb begin
    state_d      = state_q;
    load_head_in = 1'b0;
    if (in_fire) begin
      state_d      = S_FULL;
      load_head_in = 1'b1;
    end else if (out_fire) begin
      state_d = S_EMPTY;
    end
    if (flush_i) begin
      state_d      = S_EMPTY;
      load_head_in = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      head_data   <= '0;
      head_commit <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_head_in) begin
        head_data   <= in_data_i;
        head_commit <= in_commit_i;
      end
    end
  end
`endif

  // A head leaving during a flush still counts as delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_o     <= 1'b0;
      retire_cnt_o <= '0;
    end else begin
      retire_o <= out_fire & out_commit_o;
      if (out_fire && out_commit_o) begin
        retire_cnt_o <= retire_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_stage_buf.sv
// Self-checking bench for ysyx_22050019_stage_buf: queue-based reference model plus directed scenarios.
module tb_ysyx_22050019_stage_buf;
  localparam int unsigned DW = 169;
`ifdef YSYX_STAGE_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid_i = 1'b0;
  logic [DW-1:0] in_data_i = '0;
  logic          in_commit_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          out_ready_i = 1'b0;

  logic          in_ready_o, out_valid_o, out_commit_o, retire_o;
  logic [DW-1:0] out_data_o;
  logic [63:0]   retire_cnt_o;

  logic          in_ready4, out_valid4, out_commit4, retire4;
  logic [DW-1:0] out_data4;
  logic [3:0]    retire_cnt4;

  ysyx_22050019_stage_buf #(.DATA_W(DW), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .in_commit_i(in_commit_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_commit_o(out_commit_o), .retire_o(retire_o), .retire_cnt_o(retire_cnt_o)
  );

  ysyx_22050019_stage_buf #(.DATA_W(DW), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready4),
    .in_data_i(in_data_i), .in_commit_i(in_commit_i), .flush_i(flush_i),
    .out_valid_o(out_valid4), .out_ready_i(out_ready_i), .out_data_o(out_data4),
    .out_commit_o(out_commit4), .retire_o(retire4), .retire_cnt_o(retire_cnt4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of held entries, capacity CAP.
  typedef struct packed {
    logic [DW-1:0] d;
    logic          c;
  } ent_t;

  ent_t        m_q[$];
  ent_t        m_e;
  logic [63:0] m_cnt = '0;
  logic        m_ret = 1'b0;
  logic        m_of, m_if;

  function automatic logic model_ready();
    if (CAP == 2) return (m_q.size() < 2);
    return (m_q.size() == 0) || out_ready_i;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_cnt = '0;
      m_ret = 1'b0;
    end else begin
      m_of  = (m_q.size() != 0) && out_ready_i;
      m_if  = in_valid_i && model_ready() && !flush_i;
      m_ret = m_of && m_q[0].c;
      if (m_ret) m_cnt = m_cnt + 64'd1;
      if (m_of) void'(m_q.pop_front());
      if (flush_i) m_q.delete();
      if (m_if) begin
        m_e.d = in_data_i;
        m_e.c = in_commit_i;
        m_q.push_back(m_e);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("m_out_valid", DW'(out_valid_o), DW'(m_q.size() != 0));
      chk("m_in_ready", DW'(in_ready_o), DW'(model_ready()));
      if (m_q.size() != 0) begin
        chk("m_out_data", out_data_o, m_q[0].d);
        chk("m_out_commit", DW'(out_commit_o), DW'(m_q[0].c));
        chk("m4_out_data", out_data4, m_q[0].d);
        chk("m4_out_commit", DW'(out_commit4), DW'(m_q[0].c));
      end
      chk("m_retire", DW'(retire_o), DW'(m_ret));
      chk("m_retire_cnt", DW'(retire_cnt_o), DW'(m_cnt));
      chk("m4_out_valid", DW'(out_valid4), DW'(m_q.size() != 0));
      chk("m4_in_ready", DW'(in_ready4), DW'(model_ready()));
      chk("m4_retire", DW'(retire4), DW'(m_ret));
      chk("m4_retire_cnt", DW'(retire_cnt4), DW'(m_cnt[3:0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, DW'(out_valid_o), '0);
    chk({tag, "_out_commit"}, DW'(out_commit_o), '0);
    chk({tag, "_out_data"}, out_data_o, '0);
    chk({tag, "_retire"}, DW'(retire_o), '0);
    chk({tag, "_retire_cnt"}, DW'(retire_cnt_o), '0);
    chk({tag, "_in_ready"}, DW'(in_ready_o), DW'(1));
  endtask

  task automatic do_reset();
    in_valid_i  = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    rst_n       = 1'b0;
    tick();
    tick();
    check_reset_values("rst");
    rst_n = 1'b1;
  endtask

  task automatic fill_cap(input logic [7:0] base);
    out_ready_i = 1'b0;
    for (int unsigned k = 0; k < CAP; k++) begin
      in_valid_i  = 1'b1;
      in_data_i   = DW'(base + 8'(k));
      in_commit_i = 1'b1;
      tick();
    end
    in_valid_i = 1'b0;
  endtask

  task automatic stream8(input string tag);
    out_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid_i  = 1'b1;
      in_data_i   = DW'(i);
      in_commit_i = 1'b1;
      tick();
      chk({tag, "_head"}, out_data_o, DW'(i));
      chk({tag, "_valid"}, DW'(out_valid_o), DW'(1));
    end
    in_valid_i = 1'b0;
    tick();
    chk({tag, "_cnt8"}, DW'(retire_cnt_o), DW'(8));
    chk({tag, "_drained"}, DW'(out_valid_o), '0);
  endtask

  int pulses;
  logic prev_ret;

  initial begin
    // Reset values and a sustained stream
    do_reset();
    stream8("s1");

    // Backpressure ordering
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_commit_i = 1'b1; in_data_i = DW'(8'hA);
    tick();
    chk("bp_head_a", out_data_o, DW'(8'hA));
`ifdef YSYX_STAGE_SKID_EN
    chk("bp_ready_one", DW'(in_ready_o), DW'(1));
    in_data_i = DW'(8'hB);
    tick();
    chk("bp_ready_two", DW'(in_ready_o), '0);
    in_data_i = DW'(8'hC);
    tick();
    chk("bp_hold_a", out_data_o, DW'(8'hA));
    chk("bp_c_held", DW'(in_ready_o), '0);
    out_ready_i = 1'b1;
    tick();
    chk("bp_head_b", out_data_o, DW'(8'hB));
    tick();
`else
    chk("bp_ready_full", DW'(in_ready_o), '0);
    in_data_i = DW'(8'hB);
    tick();
    chk("bp_hold_a", out_data_o, DW'(8'hA));
    out_ready_i = 1'b1;
    tick();
    chk("bp_head_b", out_data_o, DW'(8'hB));
    in_data_i = DW'(8'hC);
    tick();
`endif
    chk("bp_head_c", out_data_o, DW'(8'hC));
    in_valid_i = 1'b0;
    tick();
    chk("bp_drained", DW'(out_valid_o), '0);

    // Flush while full, without and with a delivering head
    do_reset();
    fill_cap(8'hA0);
    flush_i = 1'b1; in_valid_i = 1'b1; in_data_i = DW'(8'hEE); out_ready_i = 1'b0;
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("fl_valid", DW'(out_valid_o), '0);
    chk("fl_ready", DW'(in_ready_o), DW'(1));
    chk("fl_cnt", DW'(retire_cnt_o), '0);
    tick();
    fill_cap(8'hB0);
    flush_i = 1'b1; in_valid_i = 1'b1; in_data_i = DW'(8'hEF); out_ready_i = 1'b1;
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("flo_valid", DW'(out_valid_o), '0);
    chk("flo_retire", DW'(retire_o), DW'(1));
    chk("flo_cnt", DW'(retire_cnt_o), DW'(1));
    tick();
    chk("flo_retire_end", DW'(retire_o), '0);
    chk("flo_cnt_hold", DW'(retire_cnt_o), DW'(1));

    // Mixed commit flags 1,0,1,0
    do_reset();
    out_ready_i = 1'b1;
    pulses = 0;
    prev_ret = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_valid_i  = (k < 4);
      in_data_i   = DW'(8'h40 + 8'(k));
      in_commit_i = ((k % 2) == 0);
      tick();
      if (retire_o) pulses++;
      if (retire_o && prev_ret) chk("mx_pulse_width", DW'(1), '0);
      prev_ret = retire_o;
    end
    chk("mx_pulses", DW'(pulses), DW'(2));
    chk("mx_cnt", DW'(retire_cnt_o), DW'(2));

    // Counter wrap with CNT_W = 4
    do_reset();
    out_ready_i = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      in_valid_i  = 1'b1;
      in_data_i   = DW'(i);
      in_commit_i = 1'b1;
      tick();
      if (i == 16) chk("wr_cnt15", DW'(retire_cnt4), DW'(15));
      if (i == 17) chk("wr_cnt0", DW'(retire_cnt4), '0);
    end
    in_valid_i = 1'b0;
    tick();
    chk("wr_cnt1", DW'(retire_cnt4), DW'(1));
    chk("wr_cnt17", DW'(retire_cnt_o), DW'(17));

    // Asynchronous reset while full, then a restarted stream
    fill_cap(8'hC0);
    chk("ar_full_ready", DW'(in_ready_o), '0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("ar");
    chk("ar_cnt4", DW'(retire_cnt4), '0);
    tick();
    rst_n = 1'b1;
    stream8("ar_s1");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
